// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter that owns the VGA pixel port and fills one
// requester's rectangle at a time, one pixel per cycle, clipped to the screen.
module vga_draw_arbiter #(
    parameter int NREQ = 3,
    parameter int XMAX = 320,
    parameter int YMAX = 240
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [9*NREQ-1:0] rx0,
    input  logic [8*NREQ-1:0] ry0,
    input  logic [9*NREQ-1:0] rw,
    input  logic [8*NREQ-1:0] rh,
    input  logic [3*NREQ-1:0] rcolor,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [8:0]        x,
    output logic [7:0]        y,
    output logic [2:0]        color,
    output logic              plot
);

    localparam int LGW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [9:0] XLIM = 10'(XMAX);
    localparam logic [8:0] YLIM = 9'(YMAX);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAW,
        FINISH
    } state_t;

    state_t          state, state_n;
    logic [LGW-1:0]  owner, owner_n;
    logic [LGW-1:0]  last_grant, last_grant_n;
    logic            mask_on, mask_on_n;
    logic [8:0]      x0, x0_n, w, w_n, cx, cx_n;
    logic [7:0]      y0, y0_n, h, h_n, cy, cy_n;
    logic [2:0]      col, col_n;
    logic [NREQ-1:0] grant_n, done_n;
    logic            busy_n, plot_n;
    logic [8:0]      x_n;
    logic [7:0]      y_n;
    logic [2:0]      color_n;

    logic [8:0] rx0_a [NREQ];
    logic [7:0] ry0_a [NREQ];
    logic [8:0] rw_a  [NREQ];
    logic [7:0] rh_a  [NREQ];
    logic [2:0] rc_a  [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign rx0_a[i] = rx0[9*i +: 9];
        assign ry0_a[i] = ry0[8*i +: 8];
        assign rw_a[i]  = rw[9*i +: 9];
        assign rh_a[i]  = rh[8*i +: 8];
        assign rc_a[i]  = rcolor[3*i +: 3];
    end

    logic [NREQ-1:0] elig;
    logic            win_found;
    logic [LGW-1:0]  win_idx;

    // Round-robin pick starting just after the last owner; the
    // previous owner is masked for the single IDLE cycle after FINISH.
    always_comb begin
        int idx;
        idx       = 0;
        elig      = req;
        win_found = 1'b0;
        win_idx   = '0;
        if (mask_on) elig[last_grant] = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!win_found && elig[LGW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = LGW'(idx);
            end
        end
    end

    logic       emit, last_px;
    logic [8:0] bx, ox, ncx;
    logic [7:0] by, oy, ncy;
    logic [2:0] bc;
    logic [9:0] sx;
    logic [8:0] sy;

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        mask_on_n    = 1'b0;
        x0_n         = x0;
        y0_n         = y0;
        w_n          = w;
        h_n          = h;
        col_n        = col;
        cx_n         = cx;
        cy_n         = cy;
        grant_n      = grant;
        done_n       = '0;
        plot_n       = 1'b0;
        x_n          = x;
        y_n          = y;
        color_n      = color;
        emit         = 1'b0;
        bx           = x0;
        by           = y0;
        ox           = cx;
        oy           = cy;
        bc           = col;
        last_px      = (cx == w - 9'd1) && (cy == h - 8'd1);
        if (cx == w - 9'd1) begin
            ncx = 9'd0;
            ncy = cy + 8'd1;
        end else begin
            ncx = cx + 9'd1;
            ncy = cy;
        end

        unique case (state)
            IDLE: begin
                if (win_found) begin
                    state_n = LOAD;
                    owner_n = win_idx;
                    grant_n = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                end
            end
            LOAD: begin
                x0_n  = rx0_a[owner];
                y0_n  = ry0_a[owner];
                w_n   = rw_a[owner];
                h_n   = rh_a[owner];
                col_n = rc_a[owner];
                cx_n  = 9'd0;
                cy_n  = 8'd0;
                if (rw_a[owner] == 9'd0 || rh_a[owner] == 8'd0) begin
                    state_n = FINISH;
                    done_n  = grant;
                end else begin
                    state_n = DRAW;
                    emit    = 1'b1;
                    bx      = rx0_a[owner];
                    by      = ry0_a[owner];
                    ox      = 9'd0;
                    oy      = 8'd0;
                    bc      = rc_a[owner];
                end
            end
            DRAW: begin
                if (last_px) begin
                    state_n = FINISH;
                    done_n  = grant;
                end else begin
                    cx_n = ncx;
                    cy_n = ncy;
                    emit = 1'b1;
                    ox   = ncx;
                    oy   = ncy;
                end
            end
            FINISH: begin
                state_n      = IDLE;
                grant_n      = '0;
                last_grant_n = owner;
                mask_on_n    = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        sx = {1'b0, bx} + {1'b0, ox};
        sy = {1'b0, by} + {1'b0, oy};
        if (emit && sx < XLIM && sy < YLIM) begin
            plot_n  = 1'b1;
            x_n     = sx[8:0];
            y_n     = sy[7:0];
            color_n = bc;
        end
        busy_n = (state_n != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= LGW'(NREQ - 1);
            mask_on    <= 1'b0;
            x0         <= '0;
            y0         <= '0;
            w          <= '0;
            h          <= '0;
            col        <= '0;
            cx         <= '0;
            cy         <= '0;
            grant      <= '0;
            done       <= '0;
            busy       <= 1'b0;
            plot       <= 1'b0;
            x          <= '0;
            y          <= '0;
            color      <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            mask_on    <= mask_on_n;
            x0         <= x0_n;
            y0         <= y0_n;
            w          <= w_n;
            h          <= h_n;
            col        <= col_n;
            cx         <= cx_n;
            cy         <= cy_n;
            grant      <= grant_n;
            done       <= done_n;
            busy       <= busy_n;
            plot       <= plot_n;
            x          <= x_n;
            y          <= y_n;
            color      <= color_n;
        end
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: one task per scenario,
// hand-computed expectations sampled on the falling edge.
module tb_vga_draw_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [26:0] rx0;
    logic [23:0] ry0;
    logic [26:0] rw;
    logic [23:0] rh;
    logic [8:0]  rcolor;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic        busy;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  color;
    logic        plot;

    int checks = 0;
    int failures = 0;

    vga_draw_arbiter #(.NREQ(3), .XMAX(320), .YMAX(240)) dut (
        .clk(clk), .rst(rst), .req(req),
        .rx0(rx0), .ry0(ry0), .rw(rw), .rh(rh), .rcolor(rcolor),
        .grant(grant), .done(done), .busy(busy),
        .x(x), .y(y), .color(color), .plot(plot)
    );

    always #5 clk = ~clk;

    task automatic set_rect(input int i, input int vx, input int vy,
                            input int vw, input int vh, input int vc);
        rx0[9*i +: 9]    = 9'(vx);
        ry0[8*i +: 8]    = 8'(vy);
        rw[9*i +: 9]     = 9'(vw);
        rh[8*i +: 8]     = 8'(vh);
        rcolor[3*i +: 3] = 3'(vc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        rx0 = '0; ry0 = '0; rw = '0; rh = '0; rcolor = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant, done, busy, plot, x, y, color} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got g=%b d=%b b=%b p=%b x=%0d y=%0d c=%0d exp all 0",
                     grant, done, busy, plot, x, y, color);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 3'b000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got g=%b b=%b exp 000/0", grant, busy);
        end
    endtask

    task automatic test_single();
        int ex [6] = '{10, 11, 12, 10, 11, 12};
        int ey [6] = '{20, 20, 20, 21, 21, 21};
        logic [2:0] eg;
        logic [2:0] ed;
        logic ep;
        do_reset();
        set_rect(1, 10, 20, 3, 2, 5);
        req = 3'b010;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            ep = (c >= 2 && c <= 7);
            eg = (c <= 8) ? 3'b010 : 3'b000;
            ed = (c == 8) ? 3'b010 : 3'b000;
            checks++;
            if (plot !== ep || grant !== eg || done !== ed) begin
                failures++;
                $display("FAIL single_ctl c=%0d got p=%b g=%b d=%b exp p=%b g=%b d=%b",
                         c, plot, grant, done, ep, eg, ed);
            end
            if (ep) begin
                checks++;
                if (x !== 9'(ex[c-2]) || y !== 8'(ey[c-2]) || color !== 3'd5) begin
                    failures++;
                    $display("FAIL single_pix c=%0d got (%0d,%0d,%0d) exp (%0d,%0d,5)",
                             c, x, y, color, ex[c-2], ey[c-2]);
                end
            end
            if (c == 9) begin
                checks++;
                if (x !== 9'd12 || y !== 8'd21 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL single_hold got x=%0d y=%0d b=%b exp 12,21,0",
                             x, y, busy);
                end
            end
            if (c == 3) begin
                req = 3'b000;
                set_rect(1, 100, 100, 7, 7, 1);
            end
        end
    endtask

    task automatic test_contention();
        logic [2:0] eg [13] = '{3'b001, 3'b001, 3'b001, 3'b000,
                                3'b010, 3'b010, 3'b010, 3'b000,
                                3'b100, 3'b100, 3'b100, 3'b000,
                                3'b001};
        logic [2:0] ed;
        do_reset();
        set_rect(0, 0, 5, 1, 1, 1);
        set_rect(1, 10, 5, 1, 1, 2);
        set_rect(2, 20, 5, 1, 1, 3);
        req = 3'b111;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            ed = (c == 3) ? 3'b001 : (c == 7) ? 3'b010 :
                 (c == 11) ? 3'b100 : 3'b000;
            checks++;
            if (grant !== eg[c-1] || done !== ed) begin
                failures++;
                $display("FAIL contention c=%0d got g=%b d=%b exp g=%b d=%b",
                         c, grant, done, eg[c-1], ed);
            end
            if (c == 2 || c == 6 || c == 10) begin
                checks++;
                if (plot !== 1'b1 || x !== 9'((c - 2) / 4 * 10)
                    || color !== 3'((c - 2) / 4 + 1)) begin
                    failures++;
                    $display("FAIL contention_pix c=%0d got p=%b x=%0d c=%0d exp p=1 x=%0d c=%0d",
                             c, plot, x, color, (c - 2) / 4 * 10, (c - 2) / 4 + 1);
                end
            end
        end
        req = 3'b000;
    endtask

    task automatic test_clip();
        logic [2:0] eg;
        logic [2:0] ed;
        logic ep;
        do_reset();
        set_rect(0, 318, 239, 4, 2, 6);
        req = 3'b001;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            ep = (c == 2 || c == 3);
            eg = (c <= 10) ? 3'b001 : 3'b000;
            ed = (c == 10) ? 3'b001 : 3'b000;
            checks++;
            if (plot !== ep || grant !== eg || done !== ed
                || busy !== (c <= 10)) begin
                failures++;
                $display("FAIL clip_ctl c=%0d got p=%b g=%b d=%b b=%b exp p=%b g=%b d=%b",
                         c, plot, grant, done, busy, ep, eg, ed);
            end
            if (c == 2 || c == 3 || c == 9) begin
                checks++;
                if (x !== ((c == 2) ? 9'd318 : 9'd319) || y !== 8'd239
                    || color !== 3'd6) begin
                    failures++;
                    $display("FAIL clip_pix c=%0d got (%0d,%0d,%0d) exp (%0d,239,6)",
                             c, x, y, color, (c == 2) ? 318 : 319);
                end
            end
            if (c == 10) req = 3'b000;
        end
    endtask

    task automatic test_zero();
        do_reset();
        set_rect(2, 5, 5, 0, 5, 3);
        req = 3'b100;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (plot !== 1'b0
                || grant !== ((c <= 2) ? 3'b100 : 3'b000)
                || done !== ((c == 2) ? 3'b100 : 3'b000)) begin
                failures++;
                $display("FAIL zero_size c=%0d got p=%b g=%b d=%b", c, plot, grant, done);
            end
            if (c == 2) req = 3'b000;
        end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        do_reset();
        set_rect(0, 50, 60, 4, 4, 2);
        req = 3'b001;
        repeat (4) @(negedge clk);
        checks++;
        if (plot !== 1'b1 || x !== 9'd52 || y !== 8'd60) begin
            failures++;
            $display("FAIL rstmid_third got p=%b x=%0d y=%0d exp 1,52,60", plot, x, y);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (plot !== 1'b0 || grant !== 3'b000 || done !== 3'b000
            || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_abort got p=%b g=%b d=%b b=%b exp 0", plot, grant, done, busy);
        end
        rst = 1'b0;
        req = 3'b000;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done !== 3'b000 || plot !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rstmid_quiet got activity=1 exp 0");
        end
        set_rect(0, 7, 8, 1, 1, 4);
        req = 3'b001;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (plot !== 1'b1 || x !== 9'd7 || y !== 8'd8 || color !== 3'd4) begin
                    failures++;
                    $display("FAIL rstmid_fresh_pix got p=%b (%0d,%0d,%0d) exp 1 (7,8,4)",
                             plot, x, y, color);
                end
            end
            if (c == 3) begin
                checks++;
                if (done !== 3'b001) begin
                    failures++;
                    $display("FAIL rstmid_fresh_done got %b exp 001", done);
                end
                req = 3'b000;
            end
            if (c == 4) begin
                checks++;
                if (grant !== 3'b000) begin
                    failures++;
                    $display("FAIL rstmid_fresh_idle got g=%b exp 000", grant);
                end
            end
        end
    endtask

    task automatic test_remask();
        logic [2:0] eg [6] = '{3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b100};
        do_reset();
        set_rect(2, 1, 1, 1, 1, 7);
        req = 3'b100;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (grant !== eg[c-1] || done !== ((c == 3) ? 3'b100 : 3'b000)) begin
                failures++;
                $display("FAIL remask c=%0d got g=%b d=%b exp g=%b", c, grant, done, eg[c-1]);
            end
        end
        req = 3'b000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_clip();
        test_zero();
        test_reset_mid();
        test_remask();
        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
